ofdm_cp_inserter: RTL and testbench

Transmit-side counterpart of the 32-point receive FFT path. Accepts 32-sample time-domain OFDM symbols, one sample per handshake, as produced by the TX IFFT. Buffers each symbol in a ping-pong store. Emits it as a cyclic prefix (the last CP_LEN samples) followed by the full 32-sample body, ready for the DAC/channel interface.

---
 rtl/ofdm_pkg.sv | 20 ++
 rtl/ofdm_cp_inserter_if.sv | 36 +++
 rtl/cp_sym_bank.sv | 52 +++++
 rtl/ofdm_cp_inserter.sv | 166 ++++++++++++++++
 tb/tb_ofdm_cp_inserter.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ofdm_pkg.sv
// Shared OFDM definitions: symbol geometry, complex sample type and the
// cyclic-prefix read FSM state encoding.
package ofdm_pkg;

  localparam int OFDM_N      = 32;
  localparam int OFDM_CP_LEN = 8;
  localparam int OFDM_DW     = 16;

  typedef struct packed {
    logic signed [OFDM_DW-1:0] re;
    logic signed [OFDM_DW-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CP,
    ST_BODY
  } rd_state_e;

endpackage

// File: rtl/ofdm_cp_inserter_if.sv
// Sample streams of the cyclic-prefix inserter. Optional frame markers
// out_sop/out_eop exist only when OFDM_CP_SOP_EN is defined.
interface ofdm_cp_inserter_if #(
  parameter int DW = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] din_r;
  logic signed [DW-1:0] din_i;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] dout_r;
  logic signed [DW-1:0] dout_i;
`ifdef OFDM_CP_SOP_EN
  logic                 out_sop;
  logic                 out_eop;

  modport master (
    output in_valid, din_r, din_i, out_ready,
    input  in_ready, out_valid, dout_r, dout_i, out_sop, out_eop
  );
  modport slave (
    input  in_valid, din_r, din_i, out_ready,
    output in_ready, out_valid, dout_r, dout_i, out_sop, out_eop
  );
`else
  modport master (
    output in_valid, din_r, din_i, out_ready,
    input  in_ready, out_valid, dout_r, dout_i
  );
  modport slave (
    input  in_valid, din_r, din_i, out_ready,
    output in_ready, out_valid, dout_r, dout_i
  );
`endif
endinterface

// File: rtl/cp_sym_bank.sv
// Ping-pong store of two N-entry complex symbol banks with per-bank full
// flags; combinational read port so the output register can load directly.
module cp_sym_bank
  import ofdm_pkg::*;
#(
  parameter int N  = OFDM_N,
  parameter int DW = OFDM_DW,
  parameter int AW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_wr_en,
  input  logic                 i_wr_bank,
  input  logic [AW-1:0]        i_wr_addr,
  input  logic signed [DW-1:0] i_wr_re,
  input  logic signed [DW-1:0] i_wr_im,
  input  logic                 i_set_full,
  input  logic                 i_clr_full,
  input  logic                 i_clr_bank,
  input  logic                 i_rd_bank,
  input  logic [AW-1:0]        i_rd_addr,
  output logic signed [DW-1:0] o_rd_re,
  output logic signed [DW-1:0] o_rd_im,
  output logic [1:0]           o_full
);

  logic signed [DW-1:0] r_re [2][N];
  logic signed [DW-1:0] r_im [2][N];
  logic [1:0]           r_full;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_re[i_wr_bank][i_wr_addr] <= i_wr_re;
      r_im[i_wr_bank][i_wr_addr] <= i_wr_im;
    end
  end

  // Set and clear always target different banks: the writer never owns a full bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= '0;
    end else begin
      if (i_set_full) r_full[i_wr_bank]  <= 1'b1;
      if (i_clr_full) r_full[i_clr_bank] <= 1'b0;
    end
  end

  assign o_rd_re = r_re[i_rd_bank][i_rd_addr];
  assign o_rd_im = r_im[i_rd_bank][i_rd_addr];
  assign o_full  = r_full;

endmodule

// File: rtl/ofdm_cp_inserter.sv
// OFDM transmit cyclic-prefix inserter: buffers 32-sample symbols and emits
// x[N-CP_LEN..N-1] then x[0..N-1]. Define OFDM_CP_SOP_EN for out_sop/out_eop.
module ofdm_cp_inserter
  import ofdm_pkg::*;
#(
  parameter int N      = OFDM_N,
  parameter int CP_LEN = OFDM_CP_LEN,
  parameter int DW     = OFDM_DW
) (
  input  logic clk,
  input  logic rst,
  ofdm_cp_inserter_if.slave sif
);

  localparam int            AW       = $clog2(N);
  localparam logic [AW-1:0] LAST     = AW'(N - 1);
  localparam logic [AW-1:0] CP_START = AW'(N - CP_LEN);
  localparam logic [AW-1:0] CP_NEXT  = AW'(N - CP_LEN + 1);

  logic                 r_wr_bank, r_rd_bank, w_rd_bank_nxt;
  logic [AW-1:0]        r_wr_ptr, r_rd_idx, w_rd_idx_nxt, w_rd_addr;
  rd_state_e            r_state, w_state_nxt;
  logic [1:0]           w_full;
  logic                 w_in_ready, w_wr_en, w_wr_last, w_adv;
  logic                 w_load, w_clr, w_sop, w_eop;
  logic signed [DW-1:0] w_rd_re, w_rd_im;
  logic                 r_vld_p0, r_sop_p0, r_eop_p0;
  logic signed [DW-1:0] r_dout_re_p0, r_dout_im_p0;

  assign w_in_ready = !rst && !w_full[r_wr_bank];
  assign w_wr_en    = sif.in_valid && w_in_ready;
  assign w_wr_last  = w_wr_en && (r_wr_ptr == LAST);
  assign w_adv      = !r_vld_p0 || sif.out_ready;

  cp_sym_bank #(.N(N), .DW(DW), .AW(AW)) u_bank (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (w_wr_en),
    .i_wr_bank  (r_wr_bank),
    .i_wr_addr  (r_wr_ptr),
    .i_wr_re    (sif.din_r),
    .i_wr_im    (sif.din_i),
    .i_set_full (w_wr_last),
    .i_clr_full (w_clr),
    .i_clr_bank (r_rd_bank),
    .i_rd_bank  (r_rd_bank),
    .i_rd_addr  (w_rd_addr),
    .o_rd_re    (w_rd_re),
    .o_rd_im    (w_rd_im),
    .o_full     (w_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_bank <= 1'b0;
      r_wr_ptr  <= '0;
    end else if (w_wr_en) begin
      r_wr_ptr <= w_wr_last ? '0 : r_wr_ptr + AW'(1);
      if (w_wr_last) r_wr_bank <= ~r_wr_bank;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_rd_idx_nxt  = r_rd_idx;
    w_rd_bank_nxt = r_rd_bank;
    w_rd_addr     = r_rd_idx;
    w_load        = 1'b0;
    w_clr         = 1'b0;
    w_sop         = 1'b0;
    w_eop         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_full[r_rd_bank] && w_adv) begin
          w_load    = 1'b1;
          w_rd_addr = CP_START;
          w_sop     = 1'b1;
          if (CP_LEN == 1) begin
            w_state_nxt  = ST_BODY;
            w_rd_idx_nxt = '0;
          end else begin
            w_state_nxt  = ST_CP;
            w_rd_idx_nxt = CP_NEXT;
          end
        end
      end
      ST_CP: begin
        if (w_adv) begin
          w_load = 1'b1;
          // CP is entered at CP_START only on a back-to-back symbol hand-over.
          w_sop  = (r_rd_idx == CP_START);
          if (r_rd_idx == LAST) begin
            w_state_nxt  = ST_BODY;
            w_rd_idx_nxt = '0;
          end else begin
            w_rd_idx_nxt = r_rd_idx + AW'(1);
          end
        end
      end
      ST_BODY: begin
        if (w_adv) begin
          w_load = 1'b1;
          if (r_rd_idx == LAST) begin
            w_eop         = 1'b1;
            w_clr         = 1'b1;
            w_rd_bank_nxt = ~r_rd_bank;
            if (w_full[~r_rd_bank]) begin
              w_state_nxt  = ST_CP;
              w_rd_idx_nxt = CP_START;
            end else begin
              w_state_nxt  = ST_IDLE;
              w_rd_idx_nxt = '0;
            end
          end else begin
            w_rd_idx_nxt = r_rd_idx + AW'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_rd_bank <= 1'b0;
      r_rd_idx  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_bank <= w_rd_bank_nxt;
      r_rd_idx  <= w_rd_idx_nxt;
    end
  end

  // Output register stage: holds value and markers while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p0     <= 1'b0;
      r_sop_p0     <= 1'b0;
      r_eop_p0     <= 1'b0;
      r_dout_re_p0 <= '0;
      r_dout_im_p0 <= '0;
    end else if (w_adv) begin
      r_vld_p0 <= w_load;
      r_sop_p0 <= w_load && w_sop;
      r_eop_p0 <= w_load && w_eop;
      if (w_load) begin
        r_dout_re_p0 <= w_rd_re;
        r_dout_im_p0 <= w_rd_im;
      end
    end
  end

  assign sif.in_ready  = w_in_ready;
  assign sif.out_valid = r_vld_p0;
  assign sif.dout_r    = r_dout_re_p0;
  assign sif.dout_i    = r_dout_im_p0;
`ifdef OFDM_CP_SOP_EN
  assign sif.out_sop   = r_sop_p0;
  assign sif.out_eop   = r_eop_p0;
`else
  logic w_unused_markers;
  assign w_unused_markers = r_sop_p0 ^ r_eop_p0;
`endif

endmodule

// File: tb/tb_ofdm_cp_inserter.sv
// Bench for ofdm_cp_inserter: queue-based symbol model checked on every output
// beat, plus literal expectations for CP order, latency, throughput and reset.
module tb_ofdm_cp_inserter;
  import ofdm_pkg::*;

  localparam int N  = 32;
  localparam int CP = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ofdm_cp_inserter_if #(.DW(16)) bus ();

  ofdm_cp_inserter #(.N(N), .CP_LEN(CP), .DW(16)) dut (
    .clk (clk),
    .rst (rst),
    .sif (bus)
  );

  typedef struct {
    cplx_t s;
    logic  sop;
    logic  eop;
  } exp_t;

  exp_t  exp_q[$];
  cplx_t sym_buf[$];
  int    got_re[$];
  int    got_cyc[$];
  logic  got_sop[$];
  logic  got_eop[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_in_cyc = 0;
  logic seen_inr_low = 1'b0;
  logic rdy_toggle   = 1'b0;
  logic prev_stall   = 1'b0;
  logic prev_rst     = 1'b0;
  logic signed [15:0] prev_r, prev_i;
  logic prev_sop, prev_eop;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference model and per-cycle compare, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("in_ready_in_reset", longint'(bus.in_ready), 0);
      if (prev_rst) begin
        chk("out_valid_in_reset", longint'(bus.out_valid), 0);
        chk("dout_r_in_reset", longint'(bus.dout_r), 0);
        chk("dout_i_in_reset", longint'(bus.dout_i), 0);
      end
      exp_q.delete();
      sym_buf.delete();
      prev_stall = 1'b0;
    end else begin
      if (!bus.in_ready) seen_inr_low = 1'b1;
      if (prev_stall) begin
        chk("stall_valid", longint'(bus.out_valid), 1);
        chk("stall_re", longint'(bus.dout_r), longint'(prev_r));
        chk("stall_im", longint'(bus.dout_i), longint'(prev_i));
`ifdef OFDM_CP_SOP_EN
        chk("stall_sop", longint'(bus.out_sop), longint'(prev_sop));
        chk("stall_eop", longint'(bus.out_eop), longint'(prev_eop));
`endif
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got re %0d, expected no beat", bus.dout_r);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("beat_re", longint'(bus.dout_r), longint'(e.s.re));
          chk("beat_im", longint'(bus.dout_i), longint'(e.s.im));
`ifdef OFDM_CP_SOP_EN
          chk("beat_sop", longint'(bus.out_sop), longint'(e.sop));
          chk("beat_eop", longint'(bus.out_eop), longint'(e.eop));
          got_sop.push_back(bus.out_sop);
          got_eop.push_back(bus.out_eop);
`endif
        end
        got_re.push_back(int'(bus.dout_r));
        got_cyc.push_back(cyc);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_r = bus.dout_r;
      prev_i = bus.dout_i;
`ifdef OFDM_CP_SOP_EN
      prev_sop = bus.out_sop;
      prev_eop = bus.out_eop;
`else
      prev_sop = 1'b0;
      prev_eop = 1'b0;
`endif
      if (bus.in_valid && bus.in_ready) begin
        cplx_t c;
        c.re = bus.din_r;
        c.im = bus.din_i;
        sym_buf.push_back(c);
        last_in_cyc = cyc;
        if (sym_buf.size() == N) begin
          for (int i = N - CP; i < N; i++) begin
            exp_t e;
            e.s = sym_buf[i]; e.sop = (i == N - CP); e.eop = 1'b0;
            exp_q.push_back(e);
          end
          for (int i = 0; i < N; i++) begin
            exp_t e;
            e.s = sym_buf[i]; e.sop = 1'b0; e.eop = (i == N - 1);
            exp_q.push_back(e);
          end
          sym_buf.delete();
        end
      end
    end
    prev_rst = rst;
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rdy_toggle ? ~bus.out_ready : 1'b1;
    end
  end

  task automatic clear_log();
    got_re.delete();
    got_cyc.delete();
    got_sop.delete();
    got_eop.delete();
  endtask

  task automatic send_n(input int base, input int cnt, input bit gaps);
    for (int k = 0; k < cnt; k++) begin
      int t;
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        bus.in_valid = 1'b0;
        repeat (g) begin
          @(posedge clk);
          #1;
        end
      end
      bus.in_valid = 1'b1;
      bus.din_r    = 16'(base + k);
      bus.din_i    = 16'(-(base + k));
      t = 0;
      @(negedge clk);
      while (!bus.in_ready && t < 500) begin
        t++;
        @(negedge clk);
      end
      if (!bus.in_ready) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: got in_ready 0 after %0d cycles, expected 1", t);
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(exp_q.size() == 0 && !bus.out_valid) && t < 3000);
    n_checks++;
    if (t >= 3000) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d beats pending, expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.din_r = '0;
    bus.din_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single symbol, x[k] = k - jk.
    clear_log();
    send_n(0, N, 1'b0);
    wait_idle();
    chk("t1_count", got_re.size(), 40);
    chk("t1_beat0", got_re[0], 24);
    chk("t1_beat7", got_re[7], 31);
    chk("t1_beat8", got_re[8], 0);
    chk("t1_beat39", got_re[39], 31);
    chk("t1_latency", got_cyc[0] - last_in_cyc, 2);
    chk("t1_contiguous", got_cyc[39] - got_cyc[0], 39);
`ifdef OFDM_CP_SOP_EN
    for (int i = 0; i < 40; i++) begin
      chk("t1_sop_pos", longint'(got_sop[i]), (i == 0) ? 1 : 0);
      chk("t1_eop_pos", longint'(got_eop[i]), (i == 39) ? 1 : 0);
    end
`endif

    // Three symbols back-to-back.
    clear_log();
    seen_inr_low = 1'b0;
    send_n(0, N, 1'b0);
    send_n(32, N, 1'b0);
    send_n(64, N, 1'b0);
    wait_idle();
    chk("t2_count", got_re.size(), 120);
    chk("t2_no_gap", got_cyc[119] - got_cyc[0], 119);
    chk("t2_sym1_cp", got_re[40], 56);
    chk("t2_last", got_re[119], 95);
    chk("t2_backpressure", longint'(seen_inr_low), 1);

    // Alternating out_ready.
    clear_log();
    rdy_toggle = 1'b1;
    send_n(200, N, 1'b0);
    wait_idle();
    rdy_toggle = 1'b0;
    chk("t3_count", got_re.size(), 40);
    chk("t3_beat0", got_re[0], 224);
    chk("t3_beat39", got_re[39], 231);

    // Reset with one symbol in flight and a partial one buffered.
    send_n(300, N, 1'b0);
    send_n(500, 10, 1'b0);
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    clear_log();
    send_n(100, N, 1'b0);
    wait_idle();
    chk("t4_count", got_re.size(), 40);
    chk("t4_beat0", got_re[0], 124);
    chk("t4_beat8", got_re[8], 100);
    chk("t4_beat39", got_re[39], 131);

    // Random input gaps give the same sequence as the gap-free symbol.
    clear_log();
    send_n(0, N, 1'b1);
    wait_idle();
    chk("t5_count", got_re.size(), 40);
    for (int i = 0; i < 40; i++)
      chk("t5_seq", got_re[i], (i < 8) ? (24 + i) : (i - 8));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
